// File: rtl/mux_n_pipe_pkg.sv
// Shared BIP datapath definitions: default widths, select-range helpers and
// the occupancy states of the two-entry output register pair.
package bip_dp_defs;

  localparam int unsigned BIP_WIDTH = 16;
  localparam int unsigned BIP_N_IN  = 3;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_e;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_in);
    return sel < n_in;
  endfunction

  function automatic logic sel_w_ok(input int unsigned sel_w, input int unsigned n_in);
    return (64'd1 << sel_w) >= 64'(n_in);
  endfunction

endpackage

// File: rtl/mux_n_pipe_skid_reg2.sv
// Two-entry valid/ready register pair: a registered output stage plus one skid
// entry. in_ready is a flop, so it never depends on out_ready combinationally.
module skid_reg2
  import bip_dp_defs::*;
#(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         acc;
  logic         drn;

  assign acc = in_valid && in_ready_q;
  assign drn = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SK_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        SK_EMPTY: begin
          if (acc) begin
            out_q       <= in_data;
            out_valid_q <= 1'b1;
            state       <= SK_ONE;
          end
        end
        SK_ONE: begin
          if (drn && acc) begin
            out_q <= in_data;
          end else if (drn) begin
            out_valid_q <= 1'b0;
            state       <= SK_EMPTY;
          end else if (acc) begin
            // output stalled: park the new word and close the input
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state      <= SK_TWO;
          end
        end
        SK_TWO: begin
          if (drn) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= SK_ONE;
          end
        end
        default: begin
          state       <= SK_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit selector feeding a registered valid/ready stage with skid.
// Out-of-range selects yield a zero word, an error flag and a saturating count.
module mux_n_pipe
  import bip_dp_defs::*;
#(
  parameter int unsigned WIDTH  = BIP_WIDTH,
  parameter int unsigned N_IN   = BIP_N_IN,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned ERRC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ERRC_W-1:0]     err_count,
  input  logic                  clr_err
);

  if (!sel_w_ok(SEL_W, N_IN)) begin : g_bad_sel_w
    $error("mux_n_pipe: SEL_W too narrow for N_IN");
  end

  logic [WIDTH-1:0]  sel_word;
  logic              sel_err;
  logic              acc;
  logic [ERRC_W-1:0] cnt_q;

  // Compare against each index rather than slicing by in_sel, so out-of-range
  // selects never form an out-of-bounds part select.
  always_comb begin
    sel_word = '0;
    sel_err  = !sel_in_range(32'(in_sel), N_IN);
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (32'(in_sel) == k) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign acc = in_valid && in_ready;

  skid_reg2 #(.W(WIDTH + 1)) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({sel_err, sel_word}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  ({out_sel_err, out_data}),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_err) begin
      cnt_q <= '0;
    end else if (acc && sel_err && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ERRC_W'(1);
    end
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: queue-based reference model with a per-cycle compare,
// directed literal checks, randomized traffic and a narrow-counter instance.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;

  logic        in_ready, in_ready3;
  logic [15:0] out_data, out_data3;
  logic        out_sel_err, out_sel_err3;
  logic        out_valid, out_valid3;
  logic [7:0]  err_count;
  logic [2:0]  err_count3;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(16), .N_IN(3), .SEL_W(2), .ERRC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count), .clr_err(clr_err)
  );

  mux_n_pipe #(.WIDTH(16), .N_IN(3), .SEL_W(2), .ERRC_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_sel_err(out_sel_err3), .out_valid(out_valid3), .out_ready(out_ready),
    .err_count(err_count3), .clr_err(clr_err)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: words in flight held as a plain FIFO (at most two)
  logic [16:0] m_q[$];
  int          m_cnt = 0;
  int          m_accepted = 0;
  logic        m_acc, m_drn;
  logic [15:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      m_acc = in_valid && (m_q.size() < 2);
      m_drn = (m_q.size() > 0) && out_ready;
      if (m_drn) void'(m_q.pop_front());
      if (m_acc) begin
        m_word = (in_sel < 2'd3) ? 16'((in_data >> (32'(in_sel) * 16)) & 48'hFFFF) : 16'h0;
        m_q.push_back({in_sel >= 2'd3, m_word});
        m_accepted++;
      end
      if (clr_err) m_cnt = 0;
      else if (m_acc && in_sel >= 2'd3) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(m_q[0][15:0]));
        check("out_sel_err", 32'(out_sel_err), 32'(m_q[0][16]));
      end
      check("err_count", 32'(err_count), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
      check("err_count3", 32'(err_count3), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] abc[3];
  logic        rdy_before;
  int          cycles;

  initial begin
    abc[0] = 16'h00AA; abc[1] = 16'h00BB; abc[2] = 16'h00CC;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back selection with downstream always ready
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = {16'h00CC, 16'h00BB, 16'h00AA};
    for (int i = 0; i < 3; i++) begin
      in_sel = 2'(i);
      step();
      check("seq_data", 32'(out_data), 32'(abc[i]));
      check("seq_err", 32'(out_sel_err), 32'd0);
      check("seq_in_ready", 32'(in_ready), 32'd1);
    end

    // Out-of-range selects and clear-wins
    in_sel = 2'd3;
    step();
    check("oor_data", 32'(out_data), 32'd0);
    check("oor_err", 32'(out_sel_err), 32'd1);
    step();
    check("oor_count2", 32'(err_count), 32'd2);
    clr_err = 1'b1;
    step();
    check("clr_wins", 32'(err_count), 32'd0);
    clr_err = 1'b0; in_valid = 1'b0;
    step();
    check("idle_empty", 32'(out_valid), 32'd0);

    // Stall: fill both entries, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    in_data = 48'h1;
    step();
    check("stall_w1", 32'(out_data), 32'd1);
    check("stall_rdy1", 32'(in_ready), 32'd1);
    in_data = 48'h2;
    step();
    check("stall_rdy0", 32'(in_ready), 32'd0);
    check("stall_hold", 32'(out_data), 32'd1);
    in_data = 48'h3;
    step();
    check("stall_hold2", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    step();
    check("drain_w2", 32'(out_data), 32'd2);
    check("drain_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Saturation of the 3-bit counter
    in_valid = 1'b1; in_sel = 2'd3;
    repeat (10) step();
    check("sat8", 32'(err_count), 32'd10);
    check("sat3", 32'(err_count3), 32'd7);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    step();
    step();
    check("full_before_rst", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(err_count), 32'd0);
    check("async_count3", 32'(err_count3), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_rdy", 32'(in_ready), 32'd1);
    check("post_rst_empty", 32'(out_valid), 32'd0);

    // Randomized traffic against the model
    cycles = 0;
    m_accepted = 0;
    while (m_accepted < 10000 && cycles < 60000) begin
      rdy_before = in_ready;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
      clr_err   = ($urandom_range(0, 99) == 0);
      #1;
      check("no_comb_ready", 32'(in_ready), 32'(rdy_before));
      step();
      cycles++;
    end
    check("random_budget", 32'(m_accepted >= 10000), 32'd1);

    in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    repeat (4) step();
    check("final_empty", 32'(out_valid), 32'd0);
    check("final_model_empty", 32'(m_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered valid/ready output stage and a 2-entry skid buffer.
- Successor to the fixed 3-input 16-bit combinational datapath selector.
- Used between the BIP datapath operand sources (data memory, immediate, accumulator, UART RX word) and their consumers when the consumer can stall.
- Out-of-range selects produce a zero word, as the combinational selector does. They also raise a per-word error flag and bump a saturating error counter.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- N_IN, 3, number of selectable inputs (>=2).
- SEL_W, 2, select width. Must satisfy 2**SEL_W >= N_IN; an elaboration-time check fails otherwise.
- ERRC_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select, sampled with in_data.
- in_valid  in  1  upstream word/select valid.
- in_ready  out  1  block can accept this cycle.
- out_data  out  WIDTH  selected word.
- out_sel_err  out  1  qualifies out_data: the select was >= N_IN.
- out_valid  out  1  out_data/out_sel_err valid.
- out_ready  in  1  downstream accepts.
- err_count  out  ERRC_W  count of accepted out-of-range selects, saturating.
- clr_err  in  1  synchronous clear of err_count.

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-transfer. Reset values:
  - out_valid=0, out_data=0, out_sel_err=0, err_count=0.
  - Skid entry empty. in_ready=1 after reset deasserts.
  - Any word held in the stage or the skid entry is discarded.
- Accept: a word is accepted when in_valid && in_ready at a rising edge.
- Selection at accept:
  - If in_sel < N_IN: word = slice in_sel, err = 0.
  - Otherwise: word = 0, err = 1.
  - Select and data are captured together; later changes to in_data/in_sel do not affect a held word.
- Output stage, registered: out_data, out_sel_err and out_valid are flops with no combinational path from in_* to out_*.
- Latency: one cycle from accept to out_valid while the output stage is empty or draining.
- Skid entry: one extra register holds a word accepted while the output is stalled.
- in_ready = !skid_valid. It is registered and never depends combinationally on out_ready.
- Per-cycle transitions, with A = accept and D = out_valid && out_ready:
  - Output empty, A: the word goes to the output stage.
  - Output full, D, skid empty, A: the new word replaces the output.
  - Output full, D, skid empty, no A: output empties.
  - Output full, D, skid full: skid moves to the output; skid empties; in_ready=1 next cycle. A cannot occur because in_ready=0.
  - Output full, no D, A: word goes to skid; in_ready=0 next cycle.
  - Output full, no D, skid full: hold everything.
- Throughput: with out_ready held high, one word per cycle indefinitely. No bubbles and no loss.
- Ordering is strictly FIFO; the block never drops or duplicates a word.
- err_count:
  - Increments by 1 on each accepted word with err=1.
  - Saturates at 2**ERRC_W-1 with no wrap.
  - clr_err sets it to 0 next cycle. If clr_err and an erroneous accept occur in the same cycle, clr_err wins and the result is 0.
- out_valid, once asserted, stays high with stable out_data/out_sel_err until D.
- in_valid=0 with in_ready=1 leaves all state unchanged except as draining dictates.

Decomposition:
- Shared package/header (bip_dp_defs): default WIDTH=16, default N_IN=3, and the sel-range check macro/function.
- Sub-module skid_reg2: the 2-entry valid/ready register pair, parametrised by payload width (WIDTH+1).
- mux_n_pipe holds the combinational slice select, the zero/err generation and err_count around skid_reg2.

Test Plan:
- Reset, then in_valid=1, in_data={C=16'h00CC, B=16'h00BB, A=16'h00AA}, sel cycling 0,1,2 with out_ready=1 -> out_data AA, BB, CC on consecutive cycles starting 1 cycle after first accept, out_sel_err=0, in_ready constantly 1.
- sel=3 accepted twice -> out_data=16'h0000, out_sel_err=1 each time, err_count=2. Assert clr_err with a third sel=3 accept in the same cycle -> err_count=0.
- out_ready=0, push words 1,2 -> in_ready drops to 0 after the second accept and out_data=1 holds stable. Raise out_ready -> 1 then 2 emerge in order, in_ready returns to 1; no third word accepted while in_ready=0.
- Random in_valid/out_ready (50%) over 10k words with a scoreboard -> exact in-order match and no loss or duplication; no combinational path from out_ready to in_ready (checked by assertion).
- ERRC_W=3 with 10 erroneous accepts -> err_count saturates at 7.
- Drop rst_n mid-stall with both entries full -> out_valid=0 and err_count=0 immediately (asynchronously); in_ready=1 after release; held words gone.
